// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-only RAM with a registered read port.
// Adds sub-word loads/stores (RMW) and flags misaligned accesses.
`timescale 1ns/1ps
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        ram_wren,
    output logic [29:0] ram_address,
    output logic [31:0] ram_data,
    input  logic [31:0] ram_q
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WRITE,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uext_q, uext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] ram_data_q, ram_data_d;

    logic        misalign;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Big-endian lane extraction, extension and store-lane merge
    always_comb begin
        misalign = (size == 2'b11)
                 | ((size == 2'b01) & addr[0])
                 | ((size == 2'b10) & (|addr[1:0]));
        byte_sh  = {~addr_q[1:0], 3'b000};
        half_sh  = {~addr_q[1], 4'b0000};
        ld_byte  = 8'(ram_q >> byte_sh);
        ld_half  = 16'(ram_q >> half_sh);
        load_val = ram_q;
        merged   = ram_q;
        unique case (size_q)
            2'b00: begin
                load_val = uext_q ? {24'd0, ld_byte}
                                  : {{24{ld_byte[7]}}, ld_byte};
                merged   = (ram_q & ~(32'h0000_00FF << byte_sh))
                         | (32'(wdata_q[7:0]) << byte_sh);
            end
            2'b01: begin
                load_val = uext_q ? {16'd0, ld_half}
                                  : {{16{ld_half[15]}}, ld_half};
                merged   = (ram_q & ~(32'h0000_FFFF << half_sh))
                         | (32'(wdata_q[15:0]) << half_sh);
            end
            default: begin
                load_val = ram_q;
                merged   = wdata_q;
            end
        endcase
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        uext_d     = uext_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        ram_data_d = ram_data_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    uext_d  = uext;
                    addr_d  = addr;
                    wdata_d = wdata;
                    err_d   = misalign;
                    if (misalign) begin
                        state_d = DONE;
                    end else if (we && size == 2'b10) begin
                        ram_data_d = wdata;
                        state_d    = WRITE;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: state_d = DATA;
            DATA: begin
                if (we_q) begin
                    ram_data_d = merged;
                    state_d    = WRITE;
                end else begin
                    rdata_d = load_val;
                    state_d = DONE;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uext_q     <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            ram_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uext_q     <= uext_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            ram_data_q <= ram_data_d;
        end
    end

    // Outputs decoded from state so reset removes the write strobe at once
    always_comb begin
        ready       = (state_q == IDLE);
        done        = (state_q == DONE);
        err         = (state_q == DONE) & err_q;
        ram_wren    = (state_q == WRITE);
        ram_address = addr_q[31:2];
        ram_data    = ram_data_q;
        rdata       = rdata_q;
    end

endmodule
